// File: rtl/hash_light_stream_if.sv
// Block-in / digest-out handshake bundle for hash_light_stream.
// The core uses the slave modport and the message source/digest sink uses the master modport.
interface hash_light_stream_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [8*NBYTES-1:0]   m;
  logic [8*NBYTES-1:0]   iv;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   d;
  logic                  busy;

  modport master (
    output in_valid, in_last, m, iv, out_ready,
    input  in_ready, out_valid, d, busy
  );

  modport slave (
    input  in_valid, in_last, m, iv, out_ready,
    output in_ready, out_valid, d, busy
  );
endinterface

// File: rtl/hash_light_stream.sv
// Multi-block iterative lightweight hash: chain each block, run ROUNDS rounds, finalise after the last block.
// Optional macro HASH_LIGHT_BLKCNT_EN folds the message block count (mod 256) into the top digest byte.
module hash_light_stream #(
  parameter int NBYTES = 4,
  parameter int ROUNDS = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  hash_light_stream_if.slave bus
);
  localparam int W = 8 * NBYTES;
  localparam logic [7:0] RC_LAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, ROUND, WAIT, FINAL, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   h_q, h_d;
  logic [W-1:0]   ivr_q, ivr_d;
  logic [W-1:0]   d_q, d_d;
  logic [7:0]     rc_q, rc_d;
  logic           last_q, last_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   round_h;
  logic [W-1:0]   fpx;
  logic [W-1:0]   final_d;
  logic           in_ready;
  logic           accept;

  // Per-byte round function and finalisation, all bytes in parallel from the old state.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic [7:0] t;
      assign t = h_q[8*gi +: 8] ^ ivr_q[8*gi +: 8] ^ rc_q;
      assign round_h[8*gi +: 8] = {t[4:0], t[7:5]} + h_q[8*((gi + 1) % NBYTES) +: 8];
      assign fpx[8*gi +: 8] = h_q[8*gi +: 8]
                            ^ ivr_q[8*((gi + 1) % NBYTES) +: 8]
                            ^ h_q[8*((gi + 2) % NBYTES) +: 8];
    end
  endgenerate

`ifdef HASH_LIGHT_BLKCNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign final_d = fpx ^ {cnt_q, {(W - 8){1'b0}}};
`else
  assign final_d = fpx;
`endif

  assign in_ready      = (state_q == IDLE) || (state_q == WAIT);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.d         = d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      ivr_q       <= '0;
      d_q         <= '0;
      rc_q        <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef HASH_LIGHT_BLKCNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      ivr_q       <= ivr_d;
      d_q         <= d_d;
      rc_q        <= rc_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
`ifdef HASH_LIGHT_BLKCNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    ivr_d       = ivr_q;
    d_d         = d_q;
    rc_d        = rc_q;
    last_d      = last_q;
    out_valid_d = 1'b0;
`ifdef HASH_LIGHT_BLKCNT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          ivr_d   = bus.iv;
          h_d     = bus.iv ^ bus.m;
          last_d  = bus.in_last;
          rc_d    = '0;
          state_d = ROUND;
`ifdef HASH_LIGHT_BLKCNT_EN
          cnt_d   = 8'd1;
`endif
        end
      end
      WAIT: begin
        if (accept) begin
          h_d     = h_q ^ bus.m;
          last_d  = bus.in_last;
          rc_d    = '0;
          state_d = ROUND;
`ifdef HASH_LIGHT_BLKCNT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      ROUND: begin
        h_d  = round_h;
        rc_d = rc_q + 8'd1;
        // Park rc at zero on exit so it never runs past ROUNDS-1.
        if (rc_q == RC_LAST) begin
          rc_d    = '0;
          state_d = last_q ? FINAL : WAIT;
        end
      end
      FINAL: begin
        d_d     = final_d;
        state_d = DONE;
      end
      DONE: begin
        // out_valid rises one cycle into DONE and falls with the handshake.
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hash_light_stream.sv
// Directed bench for hash_light_stream: three parameter sets (4/24, 8/1, 2/255) driven from one vector table.
module tb_hash_light_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid_t, in_last_t, out_ready_t;
  logic [63:0] m_t [3];
  logic [63:0] iv_t [3];
  logic [2:0]  in_ready_w, out_valid_w, busy_w;
  logic [63:0] d_w [3];
  logic [63:0] blk [4];
  int          checks = 0;
  int          errors = 0;

  hash_light_stream_if #(.NBYTES(4)) b0 ();
  hash_light_stream_if #(.NBYTES(8)) b1 ();
  hash_light_stream_if #(.NBYTES(2)) b2 ();

  hash_light_stream #(.NBYTES(4), .ROUNDS(24))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hash_light_stream #(.NBYTES(8), .ROUNDS(1))   u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  hash_light_stream #(.NBYTES(2), .ROUNDS(255)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.in_valid = in_valid_t[0];  assign b0.in_last = in_last_t[0];  assign b0.out_ready = out_ready_t[0];
  assign b1.in_valid = in_valid_t[1];  assign b1.in_last = in_last_t[1];  assign b1.out_ready = out_ready_t[1];
  assign b2.in_valid = in_valid_t[2];  assign b2.in_last = in_last_t[2];  assign b2.out_ready = out_ready_t[2];
  assign b0.m  = m_t[0][31:0];   assign b1.m  = m_t[1];   assign b2.m  = m_t[2][15:0];
  assign b0.iv = iv_t[0][31:0];  assign b1.iv = iv_t[1];  assign b2.iv = iv_t[2][15:0];
  assign in_ready_w  = {b2.in_ready,  b1.in_ready,  b0.in_ready};
  assign out_valid_w = {b2.out_valid, b1.out_valid, b0.out_valid};
  assign busy_w      = {b2.busy,      b1.busy,      b0.busy};
  assign d_w[0] = {32'h0, b0.d};
  assign d_w[1] = b1.d;
  assign d_w[2] = {48'h0, b2.d};

`ifdef HASH_LIGHT_BLKCNT_EN
  localparam logic [63:0] H8_ONE  = 64'h0008010000000008;
  localparam logic [63:0] H2_1234 = 64'h3512;
  localparam logic [63:0] H2_ABCD = 64'hCFAB;
`else
  localparam logic [63:0] H8_ONE  = 64'h0108010000000008;
  localparam logic [63:0] H2_1234 = 64'h3412;
  localparam logic [63:0] H2_ABCD = 64'hCDAB;
`endif

  function automatic int nb_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 8 : 2);
  endfunction

  function automatic int rounds_of(input int s);
    return (s == 0) ? 24 : ((s == 1) ? 1 : 255);
  endfunction

  function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] rotl3(input logic [7:0] x);
    return {x[4:0], x[7:5]};
  endfunction

  // Reference hash over blk[0..nblk-1] for an n-byte, r-round core.
  function automatic logic [63:0] model(input int n, input int r, input int nblk, input logic [63:0] ivv);
    logic [63:0] h, nh, dd;
    logic [7:0]  t;
    h = ivv ^ blk[0];
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) h = h ^ blk[b];
      for (int k = 0; k < r; k++) begin
        nh = '0;
        for (int i = 0; i < n; i++) begin
          t = h[8*i +: 8] ^ ivv[8*i +: 8] ^ 8'(k);
          nh[8*i +: 8] = rotl3(t) + h[8*((i + 1) % n) +: 8];
        end
        h = nh;
      end
    end
    dd = '0;
    for (int i = 0; i < n; i++)
      dd[8*i +: 8] = h[8*i +: 8] ^ ivv[8*((i + 1) % n) +: 8] ^ h[8*((i + 2) % n) +: 8];
`ifdef HASH_LIGHT_BLKCNT_EN
    dd[8*(n-1) +: 8] = dd[8*(n-1) +: 8] ^ 8'(nblk);
`endif
    return dd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds blk[0..nblk-1] to instance s, checks ready/digest latency and the output handshake.
  task automatic run_msg(input int s, input int nblk, input logic [63:0] ivv, input int stall,
                         output logic [63:0] dig);
    int n;
    int r;
    r = rounds_of(s);
    iv_t[s] = ivv;
    out_ready_t[s] = 1'b1;
    for (int b = 0; b < nblk; b++) begin
      if (b > 0 && stall > 0) begin
        iv_t[s] = '1;
        repeat (stall) tick();
      end
      m_t[s] = blk[b];
      in_last_t[s] = (b == nblk - 1);
      in_valid_t[s] = 1'b1;
      n = 0;
      while (!in_ready_w[s] && n < 1000) begin tick(); n++; end
      chk("accept_ready", 64'(in_ready_w[s]), 64'd1);
      tick();
      in_valid_t[s] = 1'b0;
      n = 0;
      if (b < nblk - 1) begin
        do begin tick(); n++; end while (!in_ready_w[s] && n < 1000);
        chk("ready_latency", 64'(n), 64'(r));
      end else begin
        do begin tick(); n++; end while (!out_valid_w[s] && n < 1000);
        chk("digest_latency", 64'(n), 64'(r + 2));
      end
    end
    dig = d_w[s];
    $display("TXN sel=%0d nbytes=%0d rounds=%0d blocks=%0d stall=%0d iv=%h digest=%h",
             s, nb_of(s), r, nblk, stall, ivv, dig);
    tick();
    chk("handshake_out_valid", 64'(out_valid_w[s]), 64'd0);
    chk("handshake_in_ready", 64'(in_ready_w[s]), 64'd1);
  endtask

  typedef struct {
    int          sel;
    int          nblk;
    int          stall;
    logic [63:0] iv;
    logic [63:0] m0, m1, m2;
    bit          use_model;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] dig, expv, hold_d;
  int          n;
  bit          seen;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1, 0, 64'h0,        64'h0,        64'h0,        64'h0,        1'b1, 64'h0};
    tbl[1] = '{0, 1, 0, 64'h01020304, 64'hA5A5A5A5, 64'h0,        64'h0,        1'b1, 64'h0};
    tbl[2] = '{0, 3, 0, 64'h01020304, 64'h11111111, 64'h22222222, 64'h33333333, 1'b1, 64'h0};
    tbl[3] = '{0, 3, 5, 64'h01020304, 64'h11111111, 64'h22222222, 64'h33333333, 1'b1, 64'h0};
    tbl[4] = '{1, 1, 0, 64'h0,        64'h1,        64'h0,        64'h0,        1'b0, H8_ONE};
    tbl[5] = '{1, 3, 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, 1'b1, 64'h0};
    tbl[6] = '{2, 1, 0, 64'h1234,     64'h00FF,     64'h0,        64'h0,        1'b0, H2_1234};
    tbl[7] = '{2, 2, 0, 64'hABCD,     64'h5A5A,     64'hC3C3,     64'h0,        1'b0, H2_ABCD};
    tbl[8] = '{2, 2, 0, 64'(16'($urandom)), 64'(16'($urandom)), 64'(16'($urandom)), 64'h0, 1'b1, 64'h0};
    tbl[9] = '{0, 2, 0, 64'(32'($urandom)), 64'(32'($urandom)), 64'(32'($urandom)), 64'h0, 1'b1, 64'h0};

    in_valid_t = '0; in_last_t = '0; out_ready_t = '0;
    for (int s = 0; s < 3; s++) begin m_t[s] = '0; iv_t[s] = '0; end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_in_ready", 64'(in_ready_w), 64'h7);
    chk("reset_out_valid", 64'(out_valid_w), 64'h0);
    chk("reset_busy", 64'(busy_w), 64'h0);
    chk("reset_d", d_w[0], 64'h0);
    rst_n = 1'b1;
    tick();

    // Abort mid-ROUND: reset must drop everything immediately and no digest may follow.
    iv_t[0] = 64'h01020304; m_t[0] = 64'hA5A5A5A5; in_last_t[0] = 1'b1; in_valid_t[0] = 1'b1;
    out_ready_t[0] = 1'b1;
    tick();
    in_valid_t[0] = 1'b0;
    repeat (9) tick();
    chk("midround_busy", 64'(busy_w[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready_w[0]), 64'd1);
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("abort_d", d_w[0], 64'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin tick(); if (out_valid_w[0]) seen = 1'b1; end
    chk("abort_no_out_valid", 64'(seen), 64'd0);

    for (int v = 0; v < 10; v++) begin
      blk[0] = tbl[v].m0; blk[1] = tbl[v].m1; blk[2] = tbl[v].m2; blk[3] = '0;
      expv = tbl[v].use_model ? model(nb_of(tbl[v].sel), rounds_of(tbl[v].sel), tbl[v].nblk, tbl[v].iv)
                              : tbl[v].exp;
      run_msg(tbl[v].sel, tbl[v].nblk, tbl[v].iv, tbl[v].stall, dig);
      chk($sformatf("digest_vec%0d", v), dig, expv);
    end

    // Output backpressure with a pending block on the input.
    blk[0] = 64'hDEADBEEF;
    expv = model(4, 24, 1, 64'h55AA00FF);
    iv_t[0] = 64'h55AA00FF; m_t[0] = blk[0]; in_last_t[0] = 1'b1; out_ready_t[0] = 1'b0;
    in_valid_t[0] = 1'b1;
    tick();
    m_t[0] = 64'h12345678;
    n = 0;
    do begin tick(); n++; end while (!out_valid_w[0] && n < 1000);
    chk("bp_latency", 64'(n), 64'd26);
    hold_d = d_w[0];
    $display("TXN sel=0 backpressure digest=%h", hold_d);
    chk("bp_digest", hold_d, expv);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_d_stable", d_w[0], hold_d);
      chk("bp_out_valid_held", 64'(out_valid_w[0]), 64'd1);
      chk("bp_no_accept", 64'(in_ready_w[0]), 64'd0);
    end
    out_ready_t[0] = 1'b1;
    tick();
    in_valid_t[0] = 1'b0;
    chk("bp_release_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready_w[0]), 64'd1);
    tick();
    chk("bp_idle_busy", 64'(busy_w[0]), 64'd0);
    chk("bp_d_kept", d_w[0], hold_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
